// File: rtl/up_io_port_if.sv
// Processor-side IN/OUT bus and output-port handshake for up_io_port.
// The master modport is the processor/consumer side; the port itself uses slave.
interface up_io_port_if;
    logic       in_req;
    logic       in_sel;
    logic [3:0] data_bus_out;
    logic       data_oe;
    logic       out_req;
    logic [3:0] data_bus_in;
    logic [3:0] FF_out;
    logic       out_valid;
    logic       out_ack;
    logic       out_busy;
    logic       overrun;

    modport master (
        output in_req, in_sel, out_req, data_bus_in, out_ack,
        input  data_bus_out, data_oe, FF_out, out_valid, out_busy, overrun
    );

    modport slave (
        input  in_req, in_sel, out_req, data_bus_in, out_ack,
        output data_bus_out, data_oe, FF_out, out_valid, out_busy, overrun
    );
endinterface

// File: rtl/up_io_port.sv
// Microprocessor I/O port: debounced pushbutton input with sticky press events,
// and a one-deep buffered output latch with valid/ack handshake and overrun flag.
module up_io_port #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   pushbuttons,
    up_io_port_if.slave  bus
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        VALID      = 2'd1,
        VALID_PEND = 2'd2
    } state_t;

    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] level_reg;
    logic [3:0] level_next;
    logic [3:0] event_reg;
    logic [3:0] event_next;
    logic [3:0] rise;
    logic       event_clear;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] ff_reg;
    logic [3:0] ff_next;
    logic [3:0] pend_reg;
    logic [3:0] pend_next;
    logic       overrun_reg;
    logic       overrun_next;

    // Two-flop synchronizer on the raw, asynchronous button pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 4'b0000;
            sync2_reg <= 4'b0000;
        end else begin
            sync1_reg <= pushbuttons;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-button debounce: the level follows sync only after it has differed
    // for DEBOUNCE_CYCLES consecutive cycles.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            logic [3:0] cnt_reg;
            logic [3:0] cnt_next;
            logic       lvl_next;

            always_comb begin
                cnt_next = cnt_reg;
                lvl_next = level_reg[gi];
                if (sync2_reg[gi] == level_reg[gi]) begin
                    cnt_next = 4'd0;
                end else if (cnt_reg == DB_LAST) begin
                    cnt_next = 4'd0;
                    lvl_next = sync2_reg[gi];
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg <= 4'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign level_next[gi] = lvl_next;
        end
    endgenerate

    // A press accepted on this edge survives an event read on the same edge.
    assign rise        = level_next & ~level_reg;
    assign event_clear = bus.in_req & bus.in_sel;
    assign event_next  = (event_reg & ~{4{event_clear}}) | rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_reg <= 4'b0000;
            event_reg <= 4'b0000;
        end else begin
            level_reg <= level_next;
            event_reg <= event_next;
        end
    end

    always_comb begin
        bus.data_oe      = bus.in_req;
        bus.data_bus_out = 4'b0000;
        if (bus.in_req) begin
            bus.data_bus_out = bus.in_sel ? event_reg : level_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            ff_reg      <= 4'b0000;
            pend_reg    <= 4'b0000;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ff_reg      <= ff_next;
            pend_reg    <= pend_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ff_next      = ff_reg;
        pend_next    = pend_reg;
        overrun_next = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (bus.out_req) begin
                    ff_next    = bus.data_bus_in;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (bus.out_ack && bus.out_req) begin
                    ff_next = bus.data_bus_in;
                end else if (bus.out_ack) begin
                    state_next = IDLE;
                end else if (bus.out_req) begin
                    pend_next  = bus.data_bus_in;
                    state_next = VALID_PEND;
                end
            end
            VALID_PEND: begin
                // On ack the pending value moves out; a same-cycle write refills it.
                if (bus.out_ack) begin
                    ff_next = pend_reg;
                    if (bus.out_req) begin
                        pend_next = bus.data_bus_in;
                    end else begin
                        state_next = VALID;
                    end
                end else if (bus.out_req) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.FF_out    = ff_reg;
    assign bus.out_valid = (state_reg != IDLE);
    assign bus.out_busy  = (state_reg == VALID_PEND);
    assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_up_io_port.sv
// Directed bench for up_io_port: button debounce/event sequences by hand,
// output handshake from a vector table of per-cycle stimulus and results.
module tb_up_io_port;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pushbuttons = 4'b0000;

    up_io_port_if bus();

    up_io_port #(.DEBOUNCE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .pushbuttons (pushbuttons),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       req;
        logic [3:0] din;
        logic       ack;
        logic [3:0] ff;
        logic       valid;
        logic       busy;
        logic       ovr;
    } out_vec_t;

    out_vec_t vecs[16];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives an IN for one combinational look; keep leaves in_req asserted
    // so the following edge consumes the read.
    task automatic expect_in(input string name, input logic sel, input logic [3:0] exp,
                             input logic keep);
        bus.in_req = 1'b1;
        bus.in_sel = sel;
        #1;
        check({name, "_oe"}, 4'(bus.data_oe), 4'b0001);
        check(name, bus.data_bus_out, exp);
        if (!keep) bus.in_req = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [3:0] ff, input logic v,
                             input logic b, input logic o);
        check({name, "_ff"}, bus.FF_out, ff);
        check({name, "_valid"}, 4'(bus.out_valid), 4'(v));
        check({name, "_busy"}, 4'(bus.out_busy), 4'(b));
        check({name, "_ovr"}, 4'(bus.overrun), 4'(o));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'b1100, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'b0010, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 4'b0101, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 4'b0110, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 4'b0111, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 4'b1001, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 4'b0000, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 4'b0000, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 4'b0000, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1};

        bus.in_req      = 1'b0;
        bus.in_sel      = 1'b0;
        bus.out_req     = 1'b0;
        bus.data_bus_in = 4'b0000;
        bus.out_ack     = 1'b0;

        repeat (3) step();
        expect_in("in_during_reset", 1'b0, 4'b0000, 1'b0);
        reset = 1'b0;
        step();
        check_out("reset_state", 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        check("idle_oe", 4'(bus.data_oe), 4'b0000);
        check("idle_data", bus.data_bus_out, 4'b0000);

        // Debounced press on bit1: level appears on the sixth edge.
        pushbuttons = 4'b0010;
        for (int i = 1; i <= 6; i++) begin
            step();
            expect_in($sformatf("press_level_c%0d", i), 1'b0,
                      (i == 6) ? 4'b0010 : 4'b0000, 1'b0);
            $display("[TB] press cycle %0d level %b", i, bus.data_bus_out);
        end
        expect_in("press_event", 1'b1, 4'b0010, 1'b1);
        step();
        bus.in_req = 1'b0;
        expect_in("event_cleared", 1'b1, 4'b0000, 1'b0);

        // Three-cycle glitch on bit0 must not pass.
        pushbuttons = 4'b0011;
        repeat (3) step();
        pushbuttons = 4'b0010;
        repeat (10) step();
        expect_in("glitch_level", 1'b0, 4'b0010, 1'b0);
        expect_in("glitch_event", 1'b1, 4'b0000, 1'b0);
        $display("[TB] glitch sequence done");

        // Release gives no event; then event set and read on the same edge.
        pushbuttons = 4'b0000;
        repeat (8) step();
        expect_in("release_level", 1'b0, 4'b0000, 1'b0);
        expect_in("release_event", 1'b1, 4'b0000, 1'b0);
        pushbuttons = 4'b1000;
        repeat (6) step();
        expect_in("bit3_event", 1'b1, 4'b1000, 1'b0);
        pushbuttons = 4'b1100;
        repeat (5) step();
        expect_in("same_edge_old", 1'b1, 4'b1000, 1'b1);
        step();
        bus.in_req = 1'b0;
        expect_in("same_edge_new", 1'b1, 4'b0100, 1'b0);
        expect_in("same_edge_level", 1'b0, 4'b1100, 1'b0);
        $display("[TB] same-edge event sequence done");

        // Reset mid-debounce abandons the pending press.
        pushbuttons = 4'b1101;
        repeat (4) step();
        reset = 1'b1;
        pushbuttons = 4'b0000;
        step();
        reset = 1'b0;
        expect_in("rst_level", 1'b0, 4'b0000, 1'b0);
        repeat (8) step();
        expect_in("rst_debounce_level", 1'b0, 4'b0000, 1'b0);
        expect_in("rst_debounce_event", 1'b1, 4'b0000, 1'b0);
        $display("[TB] reset mid-debounce done");

        // Output handshake vectors, one clock edge each.
        for (int i = 0; i < 16; i++) begin
            bus.out_req     = vecs[i].req;
            bus.data_bus_in = vecs[i].din;
            bus.out_ack     = vecs[i].ack;
            #1;
            check($sformatf("vec%0d_oe", i), 4'(bus.data_oe), 4'b0000);
            step();
            bus.out_req = 1'b0;
            bus.out_ack = 1'b0;
            check_out($sformatf("vec%0d", i), vecs[i].ff, vecs[i].valid, vecs[i].busy,
                      vecs[i].ovr);
            $display("[TB] vec %0d req=%b din=%b ack=%b -> ff=%b valid=%b busy=%b ovr=%b",
                     i, vecs[i].req, vecs[i].din, vecs[i].ack, bus.FF_out, bus.out_valid,
                     bus.out_busy, bus.overrun);
        end

        // IN and OUT in the same cycle.
        bus.out_req     = 1'b1;
        bus.data_bus_in = 4'b1010;
        expect_in("concurrent_in", 1'b0, 4'b0000, 1'b0);
        bus.in_req = 1'b1;
        step();
        bus.in_req  = 1'b0;
        bus.out_req = 1'b0;
        check_out("concurrent_out", 4'b1010, 1'b1, 1'b0, 1'b1);
        $display("[TB] concurrent IN/OUT done");

        // Reset during VALID_PEND.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out("pre_pend_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        bus.out_req = 1'b1;
        bus.data_bus_in = 4'b1000;
        step();
        bus.data_bus_in = 4'b0100;
        step();
        bus.data_bus_in = 4'b0010;
        step();
        bus.out_req = 1'b0;
        check_out("pend_before_reset", 4'b1000, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out("pend_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        check_out("pend_after_release", 4'b0000, 1'b0, 1'b0, 1'b0);
        $display("[TB] reset during VALID_PEND done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
